// File: rtl/router_fsm_ctrl.sv
// Packet-sequencing controller for the 1x3 router: steps each packet through
// header decode, payload load, FIFO-full stall and parity phases.
module router_fsm_ctrl (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;

  logic empty_din;   // empty flag of the port named by the incoming header
  logic empty_addr;  // empty flag of the latched destination
  logic soft_addr;   // soft reset of the latched destination

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    empty_din = 1'b0;
    case (data_in)
      2'd0:    empty_din = fifo_empty_0;
      2'd1:    empty_din = fifo_empty_1;
      2'd2:    empty_din = fifo_empty_2;
      default: empty_din = 1'b0;
    endcase
  end

  // Address 3 has no FIFO, so neither its empty flag nor soft reset exists.
  always_comb begin
    empty_addr = 1'b0;
    soft_addr  = 1'b0;
    case (addr_q)
      2'd0: begin
        empty_addr = fifo_empty_0;
        soft_addr  = soft_reset_0;
      end
      2'd1: begin
        empty_addr = fifo_empty_1;
        soft_addr  = soft_reset_1;
      end
      2'd2: begin
        empty_addr = fifo_empty_2;
        soft_addr  = soft_reset_2;
      end
      default: begin
        empty_addr = 1'b0;
        soft_addr  = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          addr_d = data_in;
          if (data_in != 2'd3) begin
            state_d = empty_din ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (empty_addr) state_d = LOAD_FIRST_DATA;
      end
      default: state_d = DECODE_ADDRESS;
    endcase

    // Soft reset of the addressed port overrides every transition above.
    if (state_q != DECODE_ADDRESS && soft_addr) begin
      state_d = DECODE_ADDRESS;
    end
  end

  always_comb begin
    detect_add    = (state_q == DECODE_ADDRESS);
    lfd_state     = (state_q == LOAD_FIRST_DATA);
    ld_state      = (state_q == LOAD_DATA);
    laf_state     = (state_q == LOAD_AFTER_FULL);
    full_state    = (state_q == FIFO_FULL_STATE);
    rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                    (state_q == LOAD_AFTER_FULL);
    busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);
  end

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Self-checking bench for router_fsm_ctrl: per-scenario stimulus rows push the
// expected output vector to a scoreboard queue, popped after each clock edge.
module tb_router_fsm_ctrl;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [1:0] data_in = '0;
  logic       fifo_full = 1'b0;
  logic [2:0] fifo_empty = 3'b111;
  logic [2:0] soft_reset = '0;
  logic       parity_done = 1'b0;
  logic       low_pkt_valid = 1'b0;

  logic detect_add, lfd_state, ld_state, laf_state, full_state;
  logic write_enb_reg, rst_int_reg, busy;

  // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
  logic [7:0] obs;
  assign obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                write_enb_reg, rst_int_reg, busy};

  localparam logic [7:0] S_DA   = 8'b1000_0000;
  localparam logic [7:0] S_LFD  = 8'b0100_0001;
  localparam logic [7:0] S_LD   = 8'b0010_0100;
  localparam logic [7:0] S_LAF  = 8'b0001_0101;
  localparam logic [7:0] S_FULL = 8'b0000_1001;
  localparam logic [7:0] S_LP   = 8'b0000_0101;
  localparam logic [7:0] S_CPE  = 8'b0000_0011;
  localparam logic [7:0] S_WTE  = 8'b0000_0001;

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       ff;
    logic [2:0] emp;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    logic [7:0] exp;
  } row_t;

  logic [7:0] exp_q[$];
  logic [7:0] e;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  router_fsm_ctrl dut (
    .clock         (clock),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty[0]),
    .fifo_empty_1  (fifo_empty[1]),
    .fifo_empty_2  (fifo_empty[2]),
    .soft_reset_0  (soft_reset[0]),
    .soft_reset_1  (soft_reset[1]),
    .soft_reset_2  (soft_reset[2]),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .write_enb_reg (write_enb_reg),
    .rst_int_reg   (rst_int_reg),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  function automatic row_t mk(input logic pv, input logic [1:0] din,
                              input logic ff, input logic [2:0] emp,
                              input logic [2:0] sr, input logic pd,
                              input logic lpv, input logic [7:0] exp);
    row_t r;
    r.pv = pv; r.din = din; r.ff = ff; r.emp = emp;
    r.sr = sr; r.pd = pd; r.lpv = lpv; r.exp = exp;
    return r;
  endfunction

  task automatic apply(input row_t r);
    pkt_valid     = r.pv;
    data_in       = r.din;
    fifo_full     = r.ff;
    fifo_empty    = r.emp;
    soft_reset    = r.sr;
    parity_done   = r.pd;
    low_pkt_valid = r.lpv;
  endtask

  task automatic test_reset;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    exp_q.push_back(S_DA);
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_async: got %b expected %b", obs, e);
    end
    apply(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA));
    exp_q.push_back(S_DA);
    @(posedge clock); #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_held: got %b expected %b", obs, e);
    end
    @(posedge clock); #2;
    resetn = 1'b1;
    apply(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA));
  endtask

  task automatic test_normal;
    row_t rows[$];
    rows.push_back(mk(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, S_LFD));
    rows.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD));
    rows.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD));
    rows.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD));
    rows.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD));
    rows.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LP));
    rows.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_CPE));
    rows.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA));
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL normal[%0d]: got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_busy_dest;
    row_t rows[$];
    rows.push_back(mk(1, 2'd1, 0, 3'b101, 3'b000, 0, 0, S_WTE));
    for (int k = 0; k < 5; k++)
      rows.push_back(mk(1, 2'd0, 0, 3'b101, 3'b000, 0, 0, S_WTE));
    rows.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LFD));
    rows.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD));
    rows.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LP));
    rows.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_CPE));
    rows.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA));
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL busy_dest[%0d]: got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_full_stall;
    row_t rows[$];
    rows.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LFD));
    rows.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD));
    rows.push_back(mk(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_FULL));
    rows.push_back(mk(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_FULL));
    rows.push_back(mk(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_FULL));
    rows.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 1, S_LAF));
    rows.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 1, S_LP));
    rows.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_CPE));
    rows.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA));
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL full_stall[%0d]: got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_full_priority;
    row_t rows[$];
    rows.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LFD));
    rows.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD));
    rows.push_back(mk(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_FULL));
    rows.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LAF));
    rows.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD));
    rows.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LP));
    rows.push_back(mk(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_CPE));
    rows.push_back(mk(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_FULL));
    rows.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LAF));
    rows.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 1, 1, S_DA));
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL full_priority[%0d]: got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_soft_reset;
    row_t rows[$];
    rows.push_back(mk(1, 2'd0, 0, 3'b110, 3'b000, 0, 0, S_WTE));
    rows.push_back(mk(0, 2'd0, 0, 3'b110, 3'b100, 0, 0, S_WTE));
    rows.push_back(mk(0, 2'd0, 0, 3'b110, 3'b010, 0, 0, S_WTE));
    rows.push_back(mk(0, 2'd0, 0, 3'b110, 3'b000, 0, 0, S_WTE));
    rows.push_back(mk(0, 2'd0, 0, 3'b110, 3'b001, 0, 0, S_DA));
    rows.push_back(mk(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, S_LFD));
    rows.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD));
    rows.push_back(mk(1, 2'd0, 1, 3'b111, 3'b100, 0, 0, S_DA));
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL soft_reset[%0d]: got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_invalid_addr;
    row_t rows[$];
    rows.push_back(mk(1, 2'd3, 0, 3'b111, 3'b000, 0, 0, S_DA));
    rows.push_back(mk(1, 2'd3, 0, 3'b000, 3'b000, 0, 0, S_DA));
    rows.push_back(mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, S_LFD));
    rows.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD));
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL invalid_addr[%0d]: got %b expected %b", i, obs, e);
      end
    end
  endtask

  // Entered with the DUT sitting in LOAD_DATA from the previous scenario.
  task automatic test_reset_mid_packet;
    #2 resetn = 1'b0;
    exp_q.push_back(S_DA);
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_mid_packet: got %b expected %b", obs, e);
    end
    #2 resetn = 1'b1;
    apply(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA));
    exp_q.push_back(S_DA);
    @(posedge clock); #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_mid_after: got %b expected %b", obs, e);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_busy_dest();
    test_full_stall();
    test_full_priority();
    test_soft_reset();
    test_invalid_addr();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
